uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx -- oversampled UART receiver that packs bytes into wider words.
//
// Receives LSB-first frames of UART_DATA_BITS data bits followed by
// UART_STOP_BITS stop bits. Each line bit lasts BAUD_2_CLOCK_RATIO clk
// cycles. Accepted bytes are packed least-significant byte first into an
// OUTPUT_DATA_WIDTH word, and only complete words are published.
//
// Optional feature: define UART_RX_TIMEOUT_EN to drop a partially assembled
// word when the line stays idle for two frame times. This realigns the word
// boundary after a lost byte.
//
// Ports
//   clk         system clock, all logic on the rising edge
//   rst         asynchronous active-high reset
//   rx          asynchronous serial input, idle high
//   data_out    last completely assembled word, held between updates
//   data_valid  one-cycle pulse in the cycle data_out updates
//   frame_error one-cycle pulse after a stop bit is sampled low
//   busy        high whenever the receiver is not idle
//
// OUTPUT_DATA_WIDTH must be an integer multiple of UART_DATA_BITS.
module uart_rx #(
  parameter int BAUD_2_CLOCK_RATIO = 1250,
  parameter int UART_DATA_BITS     = 8,
  parameter int UART_STOP_BITS     = 2,
  parameter int OUTPUT_DATA_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rx,
  output logic [OUTPUT_DATA_WIDTH-1:0] data_out,
  output logic                         data_valid,
  output logic                         frame_error,
  output logic                         busy
);

  localparam int BAUD  = BAUD_2_CLOCK_RATIO;
  localparam int DB    = UART_DATA_BITS;
  localparam int SB    = UART_STOP_BITS;
  localparam int BYTES = OUTPUT_DATA_WIDTH / UART_DATA_BITS;
  localparam int HALF  = BAUD / 2;
  localparam int CW    = (BAUD  > 1) ? $clog2(BAUD)  : 1;
  localparam int IW    = (DB    > 1) ? $clog2(DB)    : 1;
  localparam int SW    = (SB    > 1) ? $clog2(SB)    : 1;
  localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_HIGH = 3'd4;

  // Two-flop synchronizer. It resets to the idle line level, so reset is
  // not mistaken for a start bit.
  logic sync1_q, sync2_q;
  logic rx_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;

  logic [2:0]                   state_q, state_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [IW-1:0]                bit_q, bit_d;
  logic [SW-1:0]                stop_q, stop_d;
  logic [DB-1:0]                shift_q, shift_d;
  logic [OUTPUT_DATA_WIDTH-1:0] word_q, word_d;
  logic [BW-1:0]                byte_q, byte_d;
  logic [OUTPUT_DATA_WIDTH-1:0] dout_q, dout_d;
  logic                         dv_q, dv_d;
  logic                         fe_q, fe_d;
  logic                         to_fire;

`ifdef UART_RX_TIMEOUT_EN
  // The idle timer runs only while a partial word is pending. It clears as
  // soon as the line drops, which is also the moment the FSM leaves IDLE.
  localparam int TO_MAX = 2 * (1 + DB + SB) * BAUD;
  localparam int TW     = $clog2(TO_MAX + 1);
  logic [TW-1:0] to_q, to_d;
  logic          to_run;

  always_comb begin
    to_run  = (state_q == S_IDLE) && (byte_q != '0) && rx_s;
    to_fire = to_run && (to_q == TW'(TO_MAX - 1));
    to_d    = '0;
    if (to_run && !to_fire) to_d = to_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) to_q <= '0;
    else     to_q <= to_d;
  end
`else
  assign to_fire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    word_d  = word_q;
    byte_d  = byte_q;
    dout_d  = dout_q;
    dv_d    = 1'b0;
    fe_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (to_fire) byte_d = '0;
        if (!rx_s) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        // Recheck at mid start bit. A line that is already high again was a
        // glitch, and the FSM returns to IDLE without any report.
        if (cnt_q == CW'(HALF - 1)) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = S_DATA;
            bit_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == CW'(BAUD - 1)) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DB-1:1]};
          if (bit_q == IW'(DB - 1)) begin
            state_d = S_STOP;
            stop_d  = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == CW'(BAUD - 1)) begin
          cnt_d = '0;
          if (!rx_s) begin
            fe_d    = 1'b1;
            byte_d  = '0;
            state_d = S_WAIT_HIGH;
          end else if (stop_q == SW'(SB - 1)) begin
            // Return to IDLE at mid stop bit. This leaves half a bit of slack
            // to catch a start bit that follows with no gap.
            state_d = S_IDLE;
            for (int i = 0; i < BYTES; i++)
              if (byte_q == BW'(i)) word_d[i*DB +: DB] = shift_q;
            if (byte_q == BW'(BYTES - 1)) begin
              dout_d = word_d;
              dv_d   = 1'b1;
              byte_d = '0;
            end else begin
              byte_d = byte_q + 1'b1;
            end
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_HIGH: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      stop_q  <= '0;
      shift_q <= '0;
      word_q  <= '0;
      byte_q  <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      byte_q  <= byte_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
    end
  end

  assign data_out    = dout_q;
  assign data_valid  = dv_q;
  assign frame_error = fe_q;
  assign busy        = (state_q != S_IDLE);

endmodule
